// File: rtl/branch_predictor_param.sv
// Direct-mapped tagged BTB with per-entry saturating BHT counters, trained from EX resolution.
// Optional PRED_STATS_EN adds saturating branch/mispredict statistics counters.
module branch_predictor_param #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int CTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcf,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc
`ifdef PRED_STATS_EN
    ,
    output logic [31:0] stat_branches,
    output logic [31:0] stat_mispredicts
`endif
);

    localparam int ENTRIES = 2 ** IDX_W;
    localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
    localparam logic [CTR_W-1:0] CTR_MIN = {CTR_W{1'b0}};
    localparam logic [CTR_W-1:0] CTR_ONE = CTR_W'(32'd1);
    localparam logic [CTR_W-1:0] WT      = CTR_W'(32'd1 << (CTR_W - 1));
    localparam logic [CTR_W-1:0] WNT     = WT - CTR_ONE;

    logic [ENTRIES-1:0]             valid_r;
    logic [ENTRIES-1:0][CTR_W-1:0]  ctr_r;
    logic [TAG_W-1:0]               tag_r    [ENTRIES];
    logic [31:0]                    target_r [ENTRIES];

    logic [IDX_W-1:0] lk_idx_s;
    logic [IDX_W-1:0] up_idx_s;
    logic [TAG_W-1:0] lk_tag_s;
    logic [TAG_W-1:0] up_tag_s;
    logic             lk_hit_s;
    logic             up_hit_s;
    logic [CTR_W-1:0] up_ctr_s;
    logic [CTR_W-1:0] ctr_next_s;
    logic             unused_pc_bits_s;

    assign lk_idx_s = pcf[IDX_W+1:2];
    assign lk_tag_s = pcf[IDX_W+TAG_W+1:IDX_W+2];
    assign up_idx_s = upd_pc[IDX_W+1:2];
    assign up_tag_s = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
    assign unused_pc_bits_s = ^{pcf[1:0], pcf[31:IDX_W+TAG_W+2]};

    // Fetch-side lookup; reads pre-update contents, no bypass from the EX write
    always_comb begin
        lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == lk_tag_s);
        pred_taken = lk_hit_s & ctr_r[lk_idx_s][CTR_W-1];
        if (pred_taken) begin
            pred_target = target_r[lk_idx_s];
        end else begin
            pred_target = 32'd0;
        end
    end

    // EX-side hit detection and saturating counter step
    always_comb begin
        up_hit_s = valid_r[up_idx_s] && (tag_r[up_idx_s] == up_tag_s);
        up_ctr_s = ctr_r[up_idx_s];
        if (upd_taken) begin
            if (up_ctr_s == CTR_MAX) begin
                ctr_next_s = up_ctr_s;
            end else begin
                ctr_next_s = up_ctr_s + CTR_ONE;
            end
        end else begin
            if (up_ctr_s == CTR_MIN) begin
                ctr_next_s = up_ctr_s;
            end else begin
                ctr_next_s = up_ctr_s - CTR_ONE;
            end
        end
    end

    // Flush request and recovery PC, purely from the resolved branch
    always_comb begin
        mispredict = upd_valid & ((upd_taken ^ upd_pred_taken) |
                     (upd_taken & upd_pred_taken & (upd_target != upd_pred_target)));
        if (upd_taken) begin
            redirect_pc = upd_target;
        end else begin
            redirect_pc = upd_pc + 32'd4;
        end
    end

    // Valid/counter state: reset wins over training; tag/target left unreset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {ENTRIES{1'b0}};
            ctr_r   <= {ENTRIES{WNT}};
        end else if (upd_valid) begin
            if (up_hit_s) begin
                ctr_r[up_idx_s] <= ctr_next_s;
            end else if (upd_taken) begin
                valid_r[up_idx_s] <= 1'b1;
                ctr_r[up_idx_s]   <= WT;
            end else begin
                ctr_r[up_idx_s] <= ctr_r[up_idx_s];
            end
        end else begin
            valid_r <= valid_r;
        end
    end

    // Tag/target payload: written on any taken update that is not squashed by reset
    always_ff @(posedge clk) begin
        if (!rst && upd_valid && upd_taken) begin
            target_r[up_idx_s] <= upd_target;
            if (!up_hit_s) begin
                tag_r[up_idx_s] <= up_tag_s;
            end
        end
    end

`ifdef PRED_STATS_EN
    logic [31:0] stat_br_r;
    logic [31:0] stat_mp_r;

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_br_r <= 32'd0;
            stat_mp_r <= 32'd0;
        end else begin
            if (upd_valid && (stat_br_r != 32'hFFFF_FFFF)) begin
                stat_br_r <= stat_br_r + 32'd1;
            end
            if (mispredict && (stat_mp_r != 32'hFFFF_FFFF)) begin
                stat_mp_r <= stat_mp_r + 32'd1;
            end
        end
    end

    assign stat_branches    = stat_br_r;
    assign stat_mispredicts = stat_mp_r;
`endif

endmodule

// File: tb/tb_branch_predictor_param.sv
// Scoreboard bench for branch_predictor_param: expectations queued at drive time, checked at negedge.
module tb_branch_predictor_param;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcf;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_pred_taken;
    logic [31:0] upd_pred_target;
    logic        mispredict;
    logic [31:0] redirect_pc;
`ifdef PRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;
`endif

    always #5 clk = ~clk;

    branch_predictor_param dut (
        .clk             (clk),
        .rst             (rst),
        .pcf             (pcf),
        .pred_taken      (pred_taken),
        .pred_target     (pred_target),
        .upd_valid       (upd_valid),
        .upd_pc          (upd_pc),
        .upd_taken       (upd_taken),
        .upd_target      (upd_target),
        .upd_pred_taken  (upd_pred_taken),
        .upd_pred_target (upd_pred_target),
        .mispredict      (mispredict),
        .redirect_pc     (redirect_pc)
`ifdef PRED_STATS_EN
        ,
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
`endif
    );

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0: return {31'd0, pred_taken};
            1: return pred_target;
            2: return {31'd0, mispredict};
            3: return redirect_pc;
`ifdef PRED_STATS_EN
            4: return stat_branches;
            5: return stat_mispredicts;
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_val(input string tag, input int sel, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic expect_pred(input string tag, input logic t, input logic [31:0] tg);
        expect_val({tag, "_taken"}, 0, {31'd0, t});
        expect_val({tag, "_target"}, 1, tg);
    endtask

    task automatic expect_flush(input string tag, input logic m, input logic [31:0] rpc);
        expect_val({tag, "_mispredict"}, 2, {31'd0, m});
        if (m) expect_val({tag, "_redirect"}, 3, rpc);
    endtask

    task automatic drive(input logic [31:0] p, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utg,
                         input logic upt, input logic [31:0] uptg);
        pcf             = p;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utg;
        upd_pred_taken  = upt;
        upd_pred_target = uptg;
    endtask

    task automatic idle(input logic [31:0] p);
        drive(p, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, 32'd0);
    endtask

    // Check everything queued for this cycle at negedge, then advance past the posedge
    task automatic step();
        exp_t e;
        @(negedge clk);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk(e.tag, observe(e.sel), e.val);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        idle(32'h0000_0100);
        step();
        step();
        rst = 1'b0;

        // 1: reset then lookup
        idle(32'h0000_0100);
        expect_pred("rst_lookup", 1'b0, 32'd0);
        expect_flush("rst_idle", 1'b0, 32'd0);
        step();

        // 2: cold taken branch allocates with WT
        drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
        expect_pred("cold_same_cycle", 1'b0, 32'd0);
        expect_flush("cold", 1'b1, 32'h200);
        step();
        idle(32'h100);
        expect_pred("cold_next", 1'b1, 32'h200);
        step();

        // 3: saturate high, then step down twice
        for (int i = 0; i < 3; i++) begin
            drive(32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 1'b1, 32'h200);
            expect_flush("sat_up", 1'b0, 32'd0);
            step();
        end
        drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        expect_flush("nt1", 1'b1, 32'h104);
        step();
        idle(32'h100);
        expect_pred("after_nt1", 1'b1, 32'h200);
        step();
        drive(32'h100, 1'b1, 32'h100, 1'b0, 32'h200, 1'b1, 32'h200);
        expect_pred("nt2_same_cycle", 1'b1, 32'h200);
        step();
        idle(32'h100);
        expect_pred("after_nt2", 1'b0, 32'd0);
        step();

        // 4: alias eviction at index 0
        drive(32'h100, 1'b1, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0);
        expect_flush("alias_alloc", 1'b1, 32'h300);
        step();
        idle(32'h100);
        expect_pred("evicted", 1'b0, 32'd0);
        step();
        idle(32'h200);
        expect_pred("alias_hit", 1'b1, 32'h300);
        step();
        drive(32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
        expect_flush("alias_nt", 1'b0, 32'd0);
        step();
        idle(32'h200);
        expect_pred("alias_kept", 1'b1, 32'h300);
        step();

        // 5: target mismatch with same-cycle lookup collision
        drive(32'h104, 1'b1, 32'h104, 1'b1, 32'h200, 1'b0, 32'h0);
        step();
        drive(32'h104, 1'b1, 32'h104, 1'b1, 32'h240, 1'b1, 32'h200);
        expect_pred("collide_old", 1'b1, 32'h200);
        expect_flush("tgt_mismatch", 1'b1, 32'h240);
        step();
        idle(32'h107);
        expect_pred("collide_new_lowbits", 1'b1, 32'h240);
        step();

`ifdef PRED_STATS_EN
        // 6: statistics over 10 updates with 3 mispredicts
        rst = 1'b1;
        idle(32'h0);
        step();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(32'h10C, 1'b1, 32'h10C, 1'b1, 32'h500, (i != 0),
                  ((i == 3) || (i == 6)) ? 32'h504 : 32'h500);
            expect_flush("stat_upd", ((i == 0) || (i == 3) || (i == 6)), 32'h500);
            if (i == 0) begin
                expect_val("stat_br_start", 4, 32'd0);
                expect_val("stat_mp_start", 5, 32'd0);
            end
            step();
        end
        idle(32'h10C);
        expect_val("stat_br", 4, 32'd10);
        expect_val("stat_mp", 5, 32'd3);
        step();
`endif

        // Reset priority over a simultaneous update
        rst = 1'b1;
        drive(32'h104, 1'b1, 32'h108, 1'b1, 32'h600, 1'b0, 32'h0);
        expect_flush("rst_comb_flush", 1'b1, 32'h600);
        step();
        rst = 1'b0;
        idle(32'h108);
        expect_pred("rst_drop_upd", 1'b0, 32'd0);
`ifdef PRED_STATS_EN
        expect_val("stat_br_rst", 4, 32'd0);
        expect_val("stat_mp_rst", 5, 32'd0);
`endif
        step();
        idle(32'h104);
        expect_pred("rst_cleared", 1'b0, 32'd0);
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
